vc_pop_arbiter: RTL and testbench

//  Downstream stage of the four per-VC transaction-layer FIFOs. Pops 12-bit words from the

---
 rtl/vc_pop_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_vc_pop_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_pop_arbiter.sv
// vc_pop_arbiter: pops the four VC FIFOs in round-robin bursts and pushes the words into
// the outbound link FIFO with a fixed two-cycle pop-to-push latency.
// Optional feature: define VC_ARB_COUNT_EN to add vc_word_cnt (per-VC pushed-word counters).
module vc_pop_arbiter #(
  parameter  int unsigned BURST_LEN = 4,
  parameter  int unsigned NUM_VC    = 4,
  localparam int unsigned DATA_W    = 12,
  localparam int unsigned VC_W      = 2,
  localparam int unsigned WCNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_VC*DATA_W-1:0]  fifo_data_in,
  input  logic [NUM_VC-1:0]         fifo_empty,
  input  logic [NUM_VC-1:0]         fifo_almost_empty,
  input  logic                      sink_almost_full,
  output logic [NUM_VC-1:0]         fifo_pop,
  output logic [DATA_W-1:0]         data_out,
  output logic                      push,
  output logic [VC_W-1:0]           grant_vc,
  output logic                      busy
`ifdef VC_ARB_COUNT_EN
  ,
  output logic [NUM_VC*WCNT_W-1:0]  vc_word_cnt
`endif
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [VC_W-1:0]     grant_q, grant_d;
  logic [CNT_W-1:0]    burst_cnt_q, burst_cnt_d;
  logic [VC_W-1:0]     last_vc_q, last_vc_d;
  logic                last_flag_q, last_flag_d;
  logic                armed_q, armed_d;
  logic                pop_vld_q, pop_vld_d;
  logic [VC_W-1:0]     pop_vc_q, pop_vc_d;
  logic                push_q, push_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic                rr_found;
  logic [VC_W-1:0]     rr_vc;
  logic [VC_W-1:0]     cand;
  logic                pop_go;
  logic [VC_W-1:0]     pop_vc;
  logic [DATA_W-1:0]   src_word;

  // Round-robin pick: first non-empty VC searching from last_vc+1 upward, wrapping.
  always_comb begin
    rr_found = 1'b0;
    rr_vc    = '0;
    cand     = '0;
    for (int unsigned i = 1; i <= NUM_VC; i++) begin
      cand = last_vc_q + VC_W'(i);
      if (!rr_found && !fifo_empty[cand]) begin
        rr_found = 1'b1;
        rr_vc    = cand;
      end
    end
  end

  // Burst FSM next state and the combinational pop strobe.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    burst_cnt_d = burst_cnt_q;
    last_vc_d   = last_vc_q;
    last_flag_d = last_flag_q;
    armed_d     = 1'b1;
    pop_go      = 1'b0;
    pop_vc      = grant_q;
    fifo_pop    = '0;
    case (state_q)
      ST_IDLE: begin
        // armed_q holds off popping until the first edge after reset release
        if (armed_q && rr_found && !sink_almost_full) begin
          pop_go      = 1'b1;
          pop_vc      = rr_vc;
          grant_d     = rr_vc;
          burst_cnt_d = CNT_W'(1);
          last_flag_d = fifo_almost_empty[rr_vc];
          state_d     = ST_BURST;
        end
      end
      ST_BURST: begin
        if (!fifo_empty[grant_q] && !fifo_almost_empty[grant_q] && !sink_almost_full &&
            (burst_cnt_q < CNT_W'(BURST_LEN)) && !last_flag_q) begin
          pop_go = 1'b1;
          pop_vc = grant_q;
          if (burst_cnt_q != {CNT_W{1'b1}}) begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
          end
        end else begin
          // this no-pop cycle is the single bubble between bursts
          last_vc_d   = grant_q;
          burst_cnt_d = '0;
          last_flag_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (pop_go) begin
      fifo_pop[pop_vc] = 1'b1;
    end
  end

  // Select the word of the VC popped last cycle.
  always_comb begin
    src_word = '0;
    for (int unsigned k = 0; k < NUM_VC; k++) begin
      if (VC_W'(k) == pop_vc_q) begin
        src_word = fifo_data_in[k*DATA_W +: DATA_W];
      end
    end
  end

  // Two-stage pop-to-push pipeline; push is never gated by the sink flag.
  always_comb begin
    pop_vld_d = pop_go;
    pop_vc_d  = pop_vc;
    push_d    = pop_vld_q;
    data_d    = data_q;
    if (pop_vld_q) begin
      data_d = src_word;
    end
  end

  // State and pipeline registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      burst_cnt_q <= '0;
      last_vc_q   <= VC_W'(NUM_VC - 1);
      last_flag_q <= 1'b0;
      armed_q     <= 1'b0;
      pop_vld_q   <= 1'b0;
      pop_vc_q    <= '0;
      push_q      <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
      last_vc_q   <= last_vc_d;
      last_flag_q <= last_flag_d;
      armed_q     <= armed_d;
      pop_vld_q   <= pop_vld_d;
      pop_vc_q    <= pop_vc_d;
      push_q      <= push_d;
      data_q      <= data_d;
    end
  end

  assign data_out = data_q;
  assign push     = push_q;
  assign grant_vc = grant_q;
  assign busy     = (state_q != ST_IDLE);

`ifdef VC_ARB_COUNT_EN
  logic [NUM_VC-1:0][WCNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [VC_W-1:0]               push_vc_q, push_vc_d;

  // Count each pushed word against the VC it came from; wraps naturally.
  always_comb begin
    push_vc_d  = pop_vc_q;
    word_cnt_d = word_cnt_q;
    if (push_q) begin
      word_cnt_d[push_vc_q] = word_cnt_q[push_vc_q] + WCNT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_cnt_q <= '0;
      push_vc_q  <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
      push_vc_q  <= push_vc_d;
    end
  end

  assign vc_word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// tb_vc_pop_arbiter: source FIFO models, scoreboard and burst-level round-robin model.
`timescale 1ns/1ps
module tb_vc_pop_arbiter;
  localparam int unsigned NV    = 4;
  localparam int unsigned DW    = 12;
  localparam int          BL    = 4;
  localparam int unsigned DEPTH = 32;

  logic              clk;
  logic              reset;
  logic [NV*DW-1:0]  fifo_data_in;
  logic [NV-1:0]     fifo_empty, fifo_almost_empty, fifo_pop;
  logic              sink_almost_full;
  logic [DW-1:0]     data_out;
  logic              push;
  logic [1:0]        grant_vc;
  logic              busy;
`ifdef VC_ARB_COUNT_EN
  logic [NV*16-1:0]  vc_word_cnt;
`endif

  vc_pop_arbiter dut (
    .clk(clk), .reset(reset), .fifo_data_in(fifo_data_in), .fifo_empty(fifo_empty),
    .fifo_almost_empty(fifo_almost_empty), .sink_almost_full(sink_almost_full),
    .fifo_pop(fifo_pop), .data_out(data_out), .push(push), .grant_vc(grant_vc), .busy(busy)
`ifdef VC_ARB_COUNT_EN
    , .vc_word_cnt(vc_word_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // source FIFO models
  logic [DW-1:0] mem [NV][DEPTH];
  int            rd [NV];
  int            wr [NV];
  logic [DW-1:0] src_data [NV];
  logic [NV-1:0] pop_s;

  always_comb begin
    for (int k = 0; k < NV; k++) begin
      fifo_empty[k]              = (rd[k] == wr[k]);
      fifo_almost_empty[k]       = ((wr[k] - rd[k]) <= 1);
      fifo_data_in[k*DW +: DW]   = src_data[k];
    end
  end

  int   n_tests, n_fail, cyc, scen_start, rr_last;
  logic p1_v, p2_v, prev_pop;
  logic [DW-1:0] p1_w, p2_w;
  logic load_req, afull_plan, rst_plan;
  int   ld [NV];
  logic push_pre, push_post;
  logic [NV-1:0] pop_post;
  int   pop_vc_log[$], pop_cyc_log[$], push_w_log[$], exp_seq[$];

  typedef struct {
    int c0, c1, c2, c3;
    int exp_pops, exp_bursts, exp_first;
  } vec_t;
  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Per-cycle checks at the falling edge.
  task automatic sample();
    int pv, nb;
    pv = -1;
    nb = 0;
    for (int k = 0; k < NV; k++) if (fifo_pop[k] === 1'b1) begin nb++; pv = k; end
    check("pop_onehot", 32'(nb <= 1), 1);
    if (pv >= 0) begin
      check("pop_nonempty", fifo_empty[pv], 0);
      check("pop_while_afull", sink_almost_full, 0);
      check("busy_at_pop", busy, prev_pop);
      if (busy === 1'b1) check("grant_vc", grant_vc, pv);
      pop_vc_log.push_back(pv);
      pop_cyc_log.push_back(cyc - scen_start);
      rr_last = pv;
    end
    check("push_timing", push, p2_v);
    if (push === 1'b1) begin
      push_w_log.push_back(int'(data_out));
      if (p2_v) check("push_data", data_out, p2_w);
    end
    p2_v = p1_v;
    p2_w = p1_w;
    p1_v = (pv >= 0);
    p1_w = (pv >= 0) ? mem[pv][rd[pv]] : '0;
    prev_pop = (pv >= 0);
    pop_s = fifo_pop;
  endtask

  // One clock: update sources just after the rising edge, check at the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    push_pre = push;
    for (int k = 0; k < NV; k++) begin
      if (pop_s[k] && rd[k] != wr[k]) begin
        src_data[k] = mem[k][rd[k]];
        rd[k]++;
      end else begin
        src_data[k] = DW'($urandom);
      end
    end
    if (load_req) begin
      for (int k = 0; k < NV; k++) begin
        rd[k] = 0;
        wr[k] = ld[k];
        for (int i = 0; i < ld[k]; i++) mem[k][i] = DW'(12'h800 + k * 12'h100 + i);
      end
      load_req = 1'b0;
    end
    sink_almost_full = afull_plan;
    if (reset != rst_plan) begin
      reset = rst_plan;
      if (!rst_plan) begin
        p1_v = 1'b0; p2_v = 1'b0; prev_pop = 1'b0; rr_last = NV - 1;
      end
    end
    #1;
    push_post = push;
    pop_post  = fifo_pop;
    @(negedge clk);
    cyc++;
    sample();
  endtask

  task automatic clear_logs();
    pop_vc_log.delete(); pop_cyc_log.delete(); push_w_log.delete();
    scen_start = cyc + 1;
  endtask

  task automatic load(input int c0, input int c1, input int c2, input int c3);
    ld[0] = c0; ld[1] = c1; ld[2] = c2; ld[3] = c3;
    load_req = 1'b1;
  endtask

  task automatic drain(input bit rnd_afull);
    int budget;
    bit done;
    budget = 800;
    done = 0;
    while (!done && budget > 0) begin
      afull_plan = rnd_afull ? ($urandom_range(0, 2) == 0) : 1'b0;
      step();
      budget--;
      done = (rd[0] == wr[0]) && (rd[1] == wr[1]) && (rd[2] == wr[2]) && (rd[3] == wr[3])
             && !p1_v && !p2_v;
    end
    afull_plan = 1'b0;
    check("drain_done", done, 1);
    repeat (3) step();
    check("push_count", push_w_log.size(), pop_vc_log.size());
  endtask

  task automatic do_reset();
    rst_plan = 1'b0; step();
    rst_plan = 1'b1; step();
  endtask

  // Burst-level model: a burst is one pop plus further pops while the FIFO still holds
  // at least two words, capped at BL; next VC is the first non-empty after the last granted.
  task automatic build_model(input int c0, input int c1, input int c2, input int c3,
                             input int last_in);
    int c [NV];
    int last, g, n;
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
    last = last_in;
    exp_seq.delete();
    while (c[0] + c[1] + c[2] + c[3] > 0) begin
      g = -1;
      for (int i = 1; i <= NV; i++) if (g < 0 && c[(last + i) % NV] > 0) g = (last + i) % NV;
      n = (c[g] <= 2) ? 1 : ((c[g] - 1 < BL) ? c[g] - 1 : BL);
      for (int j = 0; j < n; j++) exp_seq.push_back(g);
      c[g] -= n;
      last = g;
    end
  endtask

  task automatic cmp_model(input string tag);
    check({tag, "_len"}, pop_vc_log.size(), exp_seq.size());
    for (int i = 0; i < exp_seq.size() && i < pop_vc_log.size(); i++)
      check({tag, "_vc"}, pop_vc_log[i], exp_seq[i]);
  endtask

  task automatic run_counts(input int c0, input int c1, input int c2, input int c3,
                            input bit rnd_afull, input string tag);
    int start_last;
    start_last = rr_last;
    clear_logs();
    load(c0, c1, c2, c3);
    afull_plan = 1'b0;
    step();
    drain(rnd_afull);
    if (!rnd_afull) begin
      build_model(c0, c1, c2, c3, start_last);
      cmp_model(tag);
    end
  endtask

  function automatic int count_bursts();
    int b;
    b = 0;
    for (int i = 0; i < pop_cyc_log.size(); i++)
      if (i == 0 || pop_cyc_log[i] != pop_cyc_log[i-1] + 1) b++;
    return b;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_pop, n_push, first_pop, g;
    int off_exp [8];
    n_tests = 0; n_fail = 0; cyc = 0; scen_start = 0; rr_last = NV - 1;
    p1_v = 0; p2_v = 0; p1_w = '0; p2_w = '0; prev_pop = 0;
    load_req = 0; afull_plan = 0; rst_plan = 0; pop_s = '0;
    for (int k = 0; k < NV; k++) begin rd[k] = 0; wr[k] = 0; src_data[k] = '0; ld[k] = 0; end
    reset = 1'b0;
    sink_almost_full = 1'b0;

    // Reset with every source FIFO holding words
    clear_logs();
    load(16, 16, 16, 16);
    repeat (3) begin
      step();
      check("rst_pop", fifo_pop, 0);
      check("rst_push", push, 0);
      check("rst_data", data_out, 0);
      check("rst_busy", busy, 0);
      check("rst_grant", grant_vc, 0);
    end
    rst_plan = 1'b1;
    step();
    check("release_no_pop", fifo_pop, 0);
    check("release_no_push", push, 0);
    step();
    check("first_grant_vc0", fifo_pop, 4'b0001);
    drain(1'b0);
    build_model(16, 16, 16, 16, NV - 1);
    cmp_model("full");

    // Directed table: word counts -> pops, bursts, first granted VC
    tbl[0] = '{0, 0, 8, 0, 8, 3, 2};
    tbl[1] = '{8, 8, 8, 8, 32, 12, 0};
    tbl[2] = '{0, 1, 0, 0, 1, 1, 1};
    tbl[3] = '{5, 0, 0, 2, 7, 4, 0};
    tbl[4] = '{1, 1, 1, 1, 4, 4, 0};
    tbl[5] = '{3, 0, 0, 0, 3, 2, 0};
    for (int t = 0; t < 6; t++) begin
      do_reset();
      run_counts(tbl[t].c0, tbl[t].c1, tbl[t].c2, tbl[t].c3, 1'b0, "tbl");
      check("tbl_pops", pop_vc_log.size(), tbl[t].exp_pops);
      check("tbl_bursts", count_bursts(), tbl[t].exp_bursts);
      check("tbl_first", (pop_vc_log.size() > 0) ? pop_vc_log[0] : -1, tbl[t].exp_first);
    end

    // VC2 only, 8 words: exact pop timing 4 / bubble / 3 / bubble / 1
    do_reset();
    run_counts(0, 0, 8, 0, 1'b0, "vc2");
    off_exp = '{0, 1, 2, 3, 5, 6, 7, 9};
    check("vc2_npops", pop_cyc_log.size(), 8);
    for (int i = 0; i < 8 && i < pop_cyc_log.size(); i++)
      check("vc2_pop_cycle", pop_cyc_log[i] - pop_cyc_log[0], off_exp[i]);
    for (int i = 0; i < 8 && i < push_w_log.size(); i++)
      check("vc2_word", push_w_log[i], 32'hA00 + i);

    // Sink almost_full rises after the second pop of a burst
    do_reset();
    clear_logs();
    load(8, 8, 0, 0);
    step(); check("af_pop1", fifo_pop, 4'b0001);
    step(); check("af_pop2", fifo_pop, 4'b0001);
    afull_plan = 1'b1;
    n_pop = 0; n_push = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 0) check("af_stop_same_cycle", fifo_pop, 0);
      n_pop += (fifo_pop != 0);
      n_push += push;
    end
    check("af_pops_held", n_pop, 0);
    check("af_inflight_pushed", n_push, 2);
    afull_plan = 1'b0;
    first_pop = 0;
    for (int i = 0; i < 5 && first_pop == 0; i++) begin
      step();
      if (fifo_pop != 0) first_pop = int'(fifo_pop);
    end
    check("af_resume_vc1", first_pop, 4'b0010);
    drain(1'b0);

    // Single word in VC1
    clear_logs();
    load(0, 1, 0, 0);
    step();
    check("one_word_pop", fifo_pop, 4'b0010);
    drain(1'b0);
    check("one_word_npops", pop_vc_log.size(), 1);
    check("one_word_data", (push_w_log.size() > 0) ? push_w_log[0] : -1, 32'h900);

    // Async reset between a pop and its push
    do_reset();
    clear_logs();
    load(8, 0, 0, 0);
    step(); check("mr_pop0", fifo_pop, 4'b0001);
    step(); check("mr_pop1", fifo_pop, 4'b0001);
    rst_plan = 1'b0;
    step();
    check("mr_push_before", push_pre, 1);
    check("mr_push_cleared", push_post, 0);
    check("mr_pop_cleared", pop_post, 0);
    rst_plan = 1'b1;
    clear_logs();
    step();
    check("mr_release_no_pop", fifo_pop, 0);
    step();
    check("mr_restart_vc0", fifo_pop, 4'b0001);
    drain(1'b0);
    check("mr_remaining", push_w_log.size(), 6);

    // Randomized scenarios: round-robin model, then random sink back-pressure
    for (int r = 0; r < 6; r++)
      run_counts($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 12),
                 $urandom_range(0, 12), 1'b0, "rnd");
    for (int r = 0; r < 6; r++) begin
      g = $urandom_range(0, 3);
      run_counts($urandom_range(0, 12), (g == 1) ? 0 : $urandom_range(0, 12),
                 $urandom_range(0, 12), $urandom_range(1, 12), 1'b1, "rnd_af");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
